jtcps2_keysend: RTL and testbench

//  Transmit side of the CPS2 key-byte stream: takes a decoded 64-bit key and a 16-bit address-range word.

---
 rtl/jtcps2_keysend_pkg.sv | 51 +++++
 rtl/jtcps2_keyinv.sv | 25 ++
 rtl/jtcps2_keysend.sv | 112 +++++++++++
 tb/tb_jtcps2_keysend.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jtcps2_keysend_pkg.sv
// Shared constants and helpers for the CPS2 key-byte transmitter: stream geometry,
// signature constants and the cfg-word to raw-bit placement used by the inverse scramble.
package jtcps2_keysend_pkg;

    localparam int KEY_BYTES = 20;
    localparam int RAW_W     = 160;
    localparam int CFG_WORDS = 10;

    localparam logic [7:0]  SUM_MASK = 8'hCF;
    localparam logic [11:0] SUM_XOR  = 12'h065;

    typedef logic [RAW_W-1:0] raw_t;

    typedef struct packed {
        logic [15:0] addr_rng;
        logic [63:0] key;
    } key_cfg_t;

    // Raw block that receives cfg word j (words 6/7 and 8/9 are swapped).
    function automatic int block_of(input int j);
        case (j)
            6:       return 7;
            7:       return 6;
            8:       return 9;
            9:       return 8;
            default: return j;
        endcase
    endfunction

    // Raw bit index for bit p of cfg word j, wrapping modulo the image width.
    function automatic int raw_index(input int j, input int p);
        int b;
        int idx;
        b = 16 * block_of(j);
        if (p >= 10)
            idx = b + 25 - p;
        else if (p >= 2)
            idx = b + 9 - p;
        else
            idx = b - 7 - p;
        return (idx + RAW_W) % RAW_W;
    endfunction

    // One step of the loader's running signature.
    function automatic logic [11:0] sum_step(input logic [11:0] s, input logic [7:0] d);
        logic [11:0] t;
        t = ((d & SUM_MASK) != 8'h00) ? (s ^ SUM_XOR) : s;
        return t + {{4{d[7]}}, d};
    endfunction

endpackage

// File: rtl/jtcps2_keyinv.sv
// Combinational inverse of the loader's bit scramble: rebuilds the 160-bit raw key
// image from the decoded key and the address-range word.
module jtcps2_keyinv
    import jtcps2_keysend_pkg::*;
(
    input  logic [15:0] addr_rng,
    input  logic [63:0] key,
    output raw_t        raw
);

    logic [RAW_W-1:0] cfg;

    assign cfg = {addr_rng, 80'd0, key};

    // Every raw bit is reached by exactly one (word, bit) pair, so this is a pure permutation.
    generate
        for (genvar gi = 0; gi < CFG_WORDS; gi++) begin : g_word
            for (genvar gb = 0; gb < 16; gb++) begin : g_bit
                localparam int IDX = raw_index(gi, gb);
                assign raw[IDX] = cfg[144 - 16*gi + gb];
            end
        end
    endgenerate

endmodule

// File: rtl/jtcps2_keysend.sv
// CPS2 key-byte transmitter: latches key/addr_rng on start, rebuilds the raw image and
// sends it LSB byte first on a dout/dout_we strobe while tracking the loader signature.
module jtcps2_keysend
    import jtcps2_keysend_pkg::*;
#(
    parameter int WE_HIGH = 2,
    parameter int WE_LOW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [15:0] addr_rng,
    output logic [7:0]  dout,
    output logic        dout_we,
    output logic        busy,
    output logic        done,
    output logic [11:0] sum
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_LOW  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int PH_MAX = (WE_HIGH > WE_LOW) ? WE_HIGH : WE_LOW;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    logic [2:0]      state_reg;
    logic [PH_W-1:0] phase_reg;
    logic [4:0]      byte_cnt_reg;
    raw_t            shift_reg;
    key_cfg_t        cfg_reg;
    logic [7:0]      dout_reg;
    logic [11:0]     sum_reg;
    raw_t            raw;
    logic [7:0]      byte_next;

    jtcps2_keyinv u_keyinv (
        .addr_rng (cfg_reg.addr_rng),
        .key      (cfg_reg.key),
        .raw      (raw)
    );

    // Byte 0 comes straight from the freshly built image; later bytes from the shifter.
    assign byte_next = (state_reg == ST_LOAD) ? raw[7:0] : shift_reg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= '0;
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
            cfg_reg      <= '0;
            dout_reg     <= '0;
            sum_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cfg_reg.addr_rng <= addr_rng;
                        cfg_reg.key      <= key;
                        sum_reg          <= '0;
                        state_reg        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_reg    <= raw >> 8;
                    dout_reg     <= byte_next;
                    sum_reg      <= sum_step(sum_reg, byte_next);
                    byte_cnt_reg <= '0;
                    phase_reg    <= '0;
                    state_reg    <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (phase_reg == PH_W'(WE_HIGH - 1)) begin
                        phase_reg <= '0;
                        state_reg <= ST_LOW;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_reg == PH_W'(WE_LOW - 1)) begin
                        phase_reg <= '0;
                        if (byte_cnt_reg == 5'(KEY_BYTES - 1)) begin
                            state_reg <= ST_DONE;
                        end else begin
                            shift_reg    <= shift_reg >> 8;
                            dout_reg     <= byte_next;
                            sum_reg      <= sum_step(sum_reg, byte_next);
                            byte_cnt_reg <= byte_cnt_reg + 5'd1;
                            state_reg    <= ST_HIGH;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign dout    = dout_reg;
    assign dout_we = (state_reg == ST_HIGH);
    assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_HIGH) || (state_reg == ST_LOW);
    assign done    = (state_reg == ST_DONE);
    assign sum     = sum_reg;

endmodule

// File: tb/tb_jtcps2_keysend.sv
// Bench for jtcps2_keysend: known-answer vectors, abort/ignore sequences and random
// transfers checked byte by byte against a scoreboard fed by an independent model.
module tb_jtcps2_keysend;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key;
    logic [15:0] addr_rng;
    logic [7:0]  dout;
    logic        dout_we;
    logic        busy;
    logic        done;
    logic [11:0] sum;

    always #5 clk = ~clk;

    jtcps2_keysend #(.WE_HIGH(2), .WE_LOW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .addr_rng (addr_rng),
        .dout     (dout),
        .dout_we  (dout_we),
        .busy     (busy),
        .done     (done),
        .sum      (sum)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  cap[20];
    int          strobe_cnt = 0;
    logic        we_prev    = 1'b0;
    logic [7:0]  dout_prev  = 8'h00;
    logic        mon_skip   = 1'b1;
    logic [7:0]  mon_e;
    logic [11:0] exp_sum;

    // In-block raw offset for each word bit, and the word->block order.
    int offs[16] = '{-7, -8, 7, 6, 5, 4, 3, 2, 1, 0, 15, 14, 13, 12, 11, 10};
    int blk[10]  = '{0, 1, 2, 3, 4, 5, 7, 6, 9, 8};

    typedef struct {
        logic [63:0] key;
        logic [15:0] addr;
        int          nz_idx;
        logic [7:0]  nz_val;
        logic [11:0] sum;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] model_raw(input logic [63:0] k, input logic [15:0] a);
        logic [159:0] cfg;
        logic [159:0] r;
        cfg = {a, 80'd0, k};
        r   = '0;
        for (int j = 0; j < 10; j++)
            for (int p = 0; p < 16; p++)
                r[(blk[j]*16 + offs[p] + 160) % 160] = cfg[144 - 16*j + p];
        return r;
    endfunction

    function automatic logic [11:0] model_sum(input logic [159:0] r);
        logic [11:0] s;
        logic [7:0]  d;
        s = '0;
        for (int n = 0; n < 20; n++) begin
            d = r[8*n +: 8];
            if ((d & 8'hCF) != 8'h00) s = s ^ 12'h065;
            s = s + {{4{d[7]}}, d};
        end
        return s;
    endfunction

    // Monitor: pops one expected byte per strobe rising edge; dout must not move otherwise.
    always @(negedge clk) begin
        if (!mon_skip && !rst) begin
            if (dout_we && !we_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected strobe", 64'(dout_we), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("byte%0d", strobe_cnt), 64'(dout), 64'(mon_e));
                end
                if (strobe_cnt < 20) cap[strobe_cnt] = dout;
                strobe_cnt++;
            end else begin
                chk("dout stable", 64'(dout), 64'(dout_prev));
            end
        end
        we_prev   = dout_we;
        dout_prev = dout;
    end

    // mode 0: plain, 1: start pulses during busy and in DONE, 2: reset during byte 7 HIGH
    task automatic run_xfer(input logic [63:0] k, input logic [15:0] a, input int mode);
        logic [159:0] r;
        int           cyc;
        r = model_raw(k, a);
        exp_q.delete();
        for (int n = 0; n < 20; n++) exp_q.push_back(r[8*n +: 8]);
        exp_sum    = model_sum(r);
        strobe_cnt = 0;
        @(negedge clk);
        start    = 1'b1;
        key      = k;
        addr_rng = a;
        @(negedge clk);
        start    = 1'b0;
        key      = ~k;
        addr_rng = ~a;
        cyc = 1;
        chk("busy in LOAD", 64'(busy), 64'(1));
        while (!done && cyc < 200) begin
            if (mode == 1) start = (cyc == 10);
            if (mode == 2 && cyc == 31) begin
                chk("we in byte7 HIGH", 64'(dout_we), 64'(1));
                mon_skip = 1'b1;
                rst      = 1'b1;
                @(negedge clk);
                chk("we after rst", 64'(dout_we), 64'(0));
                chk("busy after rst", 64'(busy), 64'(0));
                chk("sum after rst", 64'(sum), 64'(0));
                chk("done after rst", 64'(done), 64'(0));
                chk("strobes before rst", 64'(strobe_cnt), 64'(8));
                rst = 1'b0;
                repeat (2) @(negedge clk);
                chk("busy stays low", 64'(busy), 64'(0));
                exp_q.delete();
                mon_skip = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done seen", 64'(done), 64'(1));
        chk("done cycle", 64'(cyc), 64'(82));
        chk("busy at done", 64'(busy), 64'(0));
        chk("sum", 64'(sum), 64'(exp_sum));
        chk("strobes", 64'(strobe_cnt), 64'(20));
        chk("queue left", 64'(exp_q.size()), 64'(0));
        if (mode == 1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done one cycle", 64'(done), 64'(0));
        chk("busy after done", 64'(busy), 64'(0));
        if (mode == 1) begin
            repeat (3) @(negedge clk);
            chk("start in DONE ignored", 64'(busy), 64'(0));
            chk("sum holds", 64'(sum), 64'(exp_sum));
        end
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{64'h0,                   16'h0000, -1, 8'h00, 12'h000};
        vecs[1] = '{64'h0,                   16'h8000,  1, 8'h04, 12'h069};
        vecs[2] = '{64'h1,                   16'h0000, 15, 8'h02, 12'h067};
        vecs[3] = '{64'h8000_0000_0000_0000, 16'h0000, 15, 8'h04, 12'h069};
        vecs[4] = '{64'h0,                   16'h0001, 19, 8'h02, 12'h067};

        rst      = 1'b1;
        start    = 1'b0;
        key      = '0;
        addr_rng = '0;
        repeat (3) @(negedge clk);
        chk("rst dout", 64'(dout), 64'(0));
        chk("rst dout_we", 64'(dout_we), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst sum", 64'(sum), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].key, vecs[v].addr, 0);
            for (int n = 0; n < 20; n++)
                chk($sformatf("vec%0d byte%0d", v, n), 64'(cap[n]),
                    64'((n == vecs[v].nz_idx) ? vecs[v].nz_val : 8'h00));
            chk($sformatf("vec%0d sum", v), 64'(sum), 64'(vecs[v].sum));
            $display("vector %0d key=%h addr=%h sum=%h", v, vecs[v].key, vecs[v].addr, sum);
        end

        run_xfer({$urandom, $urandom}, 16'($urandom), 1);
        $display("ignore-start transfer sum=%h", sum);
        run_xfer({$urandom, $urandom}, 16'($urandom), 2);
        $display("reset-abort transfer");
        run_xfer({$urandom, $urandom}, 16'($urandom), 0);
        $display("post-reset transfer sum=%h", sum);

        for (int i = 0; i < 200; i++) begin
            logic [63:0] rk;
            logic [15:0] ra;
            rk = {$urandom, $urandom};
            ra = 16'($urandom);
            run_xfer(rk, ra, 0);
            $display("random %0d key=%h addr=%h sum=%h", i, rk, ra, sum);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
